// File: rtl/bool_sweep_pkg.sv
// rtl/bool_sweep_pkg.sv - shared types and constants for the boolean sweep engine
package bool_sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int EVAL_LAT = 2;
  localparam int SIG_W    = 16;

  // Vector layout is {a, b, or_in[OR_W-1:0], f}
  localparam int F_BIT  = 0;
  localparam int OR_LSB = 1;

  function automatic int B_BIT(input int or_w);
    return or_w + 1;
  endfunction

  function automatic int A_BIT(input int or_w);
    return or_w + 2;
  endfunction

endpackage

// File: rtl/bool_sweep_engine_eval.sv
// rtl/bool_sweep_engine_eval.sv - bool_eval: two-stage registered y1/y2 evaluator
module bool_eval
  import bool_sweep_pkg::*;
#(
  parameter int OR_W = 3,
  parameter int IN_W = OR_W + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] vec,
  input  logic            vec_valid,
  output logic            y1,
  output logic            y2,
  output logic            y_valid
);

  logic a_q, b_q, f_q, or_q, v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      f_q     <= 1'b0;
      or_q    <= 1'b0;
      v_q     <= 1'b0;
      y1      <= 1'b0;
      y2      <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      v_q     <= vec_valid;
      y_valid <= v_q;
      // Only first-cycle vectors are sampled, so dwell repeats leave the pipe idle
      if (vec_valid) begin
        a_q  <= vec[A_BIT(OR_W)];
        b_q  <= vec[B_BIT(OR_W)];
        f_q  <= vec[F_BIT];
        or_q <= |vec[OR_LSB +: OR_W];
      end
      if (v_q) begin
        y1 <= a_q ^ or_q;
        y2 <= ~b_q & or_q & f_q;
      end
    end
  end

endmodule

// File: rtl/bool_sweep_engine.sv
// rtl/bool_sweep_engine.sv - vector sweep sequencer with ones counters; BOOL_SWEEP_SIGNATURE_EN adds a 16-bit signature
module bool_sweep_engine
  import bool_sweep_pkg::*;
#(
  parameter int OR_W  = 3,
  parameter int DWELL = 1,
  parameter int IN_W  = OR_W + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] limit,
  output logic            busy,
  output logic            done,
  output logic [IN_W-1:0] vec_out,
  output logic            vec_valid,
  output logic            y1,
  output logic            y2,
  output logic            y_valid,
  output logic [IN_W:0]   y1_count,
  output logic [IN_W:0]   y2_count
`ifdef BOOL_SWEEP_SIGNATURE_EN
  ,
  output logic [SIG_W-1:0] signature
`endif
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  state_t            state, state_n;
  logic              arm, accept, pending;
  logic [IN_W-1:0]   lim, vec_n;
  logic [DW_W-1:0]   dwell, dwell_n;
  logic              vv_n;
  logic [EVAL_LAT-2:0] vv_sr;

  // arm delays the first vector by one cycle after the accepting edge
  assign accept  = (state == IDLE) && !arm && start;
  assign busy    = (state != IDLE) || arm;
  assign done    = (state == DONE);
  assign pending = vec_valid || (|vv_sr);

  always_comb begin
    state_n = state;
    vec_n   = vec_out;
    dwell_n = dwell;
    vv_n    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_n = RUN;
          vec_n   = '0;
          dwell_n = '0;
          vv_n    = 1'b1;
        end
      end
      RUN: begin
        if (dwell == DW_LAST) begin
          if (vec_out != lim) begin
            vec_n   = vec_out + IN_W'(1);
            dwell_n = '0;
            vv_n    = 1'b1;
          end else begin
            state_n = pending ? DRAIN : DONE;
          end
        end else begin
          dwell_n = dwell + DW_W'(1);
        end
      end
      DRAIN:   if (!pending) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arm       <= 1'b0;
      lim       <= '0;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      dwell     <= '0;
      vv_sr     <= '0;
      y1_count  <= '0;
      y2_count  <= '0;
    end else begin
      state     <= state_n;
      arm       <= accept;
      vec_out   <= vec_n;
      vec_valid <= vv_n;
      dwell     <= dwell_n;
      vv_sr[0]  <= vec_valid;
      for (int i = 1; i < EVAL_LAT - 1; i++) vv_sr[i] <= vv_sr[i-1];
      if (accept) begin
        lim      <= limit;
        y1_count <= '0;
        y2_count <= '0;
      end else if (y_valid) begin
        y1_count <= y1_count + (IN_W+1)'(y1);
        y2_count <= y2_count + (IN_W+1)'(y2);
      end
    end
  end

`ifdef BOOL_SWEEP_SIGNATURE_EN
  always_ff @(posedge clk) begin
    if (rst || accept) signature <= '0;
    else if (y_valid)  signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ {{(SIG_W-2){1'b0}}, y1, y2};
  end
`endif

  bool_eval #(.OR_W(OR_W), .IN_W(IN_W)) u_eval (
    .clk       (clk),
    .rst       (rst),
    .vec       (vec_out),
    .vec_valid (vec_valid),
    .y1        (y1),
    .y2        (y2),
    .y_valid   (y_valid)
  );

endmodule

// File: tb/tb_bool_sweep_engine.sv
// tb/tb_bool_sweep_engine.sv - directed self-checking bench for bool_sweep_engine
module tb_bool_sweep_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b, start_c;
  logic [5:0] limit_a, limit_b;
  logic [3:0] limit_c;

  logic busy_a, done_a, vv_a, y1_a, y2_a, yv_a;
  logic [5:0] vec_a;
  logic [6:0] y1c_a, y2c_a;
  logic busy_b, done_b, vv_b, y1_b, y2_b, yv_b;
  logic [5:0] vec_b;
  logic [6:0] y1c_b, y2c_b;
  logic busy_c, done_c, vv_c, y1_c, y2_c, yv_c;
  logic [3:0] vec_c;
  logic [4:0] y1c_c, y2c_c;
`ifdef BOOL_SWEEP_SIGNATURE_EN
  logic [15:0] sig_a, sig_b, sig_c;
`endif

  bool_sweep_engine #(.OR_W(3), .DWELL(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .limit(limit_a),
    .busy(busy_a), .done(done_a), .vec_out(vec_a), .vec_valid(vv_a),
    .y1(y1_a), .y2(y2_a), .y_valid(yv_a), .y1_count(y1c_a), .y2_count(y2c_a)
`ifdef BOOL_SWEEP_SIGNATURE_EN
    , .signature(sig_a)
`endif
  );

  bool_sweep_engine #(.OR_W(3), .DWELL(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .limit(limit_b),
    .busy(busy_b), .done(done_b), .vec_out(vec_b), .vec_valid(vv_b),
    .y1(y1_b), .y2(y2_b), .y_valid(yv_b), .y1_count(y1c_b), .y2_count(y2c_b)
`ifdef BOOL_SWEEP_SIGNATURE_EN
    , .signature(sig_b)
`endif
  );

  bool_sweep_engine #(.OR_W(1), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .limit(limit_c),
    .busy(busy_c), .done(done_c), .vec_out(vec_c), .vec_valid(vv_c),
    .y1(y1_c), .y2(y2_c), .y_valid(yv_c), .y1_count(y1c_c), .y2_count(y2c_c)
`ifdef BOOL_SWEEP_SIGNATURE_EN
    , .signature(sig_c)
`endif
  );

  int sel;
  logic m_busy, m_done, m_vv, m_y1, m_y2, m_yv;
  logic [7:0] m_vec, m_y1c, m_y2c;
  logic [15:0] m_sig;

  always_comb begin
    m_busy = busy_a; m_done = done_a; m_vv = vv_a; m_y1 = y1_a; m_y2 = y2_a; m_yv = yv_a;
    m_vec = 8'(vec_a); m_y1c = 8'(y1c_a); m_y2c = 8'(y2c_a); m_sig = '0;
`ifdef BOOL_SWEEP_SIGNATURE_EN
    m_sig = sig_a;
`endif
    if (sel == 1) begin
      m_busy = busy_b; m_done = done_b; m_vv = vv_b; m_y1 = y1_b; m_y2 = y2_b; m_yv = yv_b;
      m_vec = 8'(vec_b); m_y1c = 8'(y1c_b); m_y2c = 8'(y2c_b);
`ifdef BOOL_SWEEP_SIGNATURE_EN
      m_sig = sig_b;
`endif
    end else if (sel == 2) begin
      m_busy = busy_c; m_done = done_c; m_vv = vv_c; m_y1 = y1_c; m_y2 = y2_c; m_yv = yv_c;
      m_vec = 8'(vec_c); m_y1c = 8'(y1c_c); m_y2c = 8'(y2c_c);
`ifdef BOOL_SWEEP_SIGNATURE_EN
      m_sig = sig_c;
`endif
    end
  end

  int total = 0;
  int bad = 0;

  // Results of the most recent run_sweep call
  int yv_n, y1_n, vv_n, done_at, done_n, seq_err, y_err;
  int vv_at [3];
  logic busy_after;
  logic [15:0] sig_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_y(input int v, input int orw);
    bit f, o, b, a;
    f = (v & 1) != 0;
    o = ((v >> 1) & ((1 << orw) - 1)) != 0;
    b = ((v >> (orw + 1)) & 1) != 0;
    a = ((v >> (orw + 2)) & 1) != 0;
    return {a ^ o, !b && o && f};
  endfunction

  task automatic set_start(input int s, input logic val);
    if (s == 0) start_a = val;
    else if (s == 1) start_b = val;
    else start_c = val;
  endtask

  // Called at a negedge; hold keeps start high until after done and alters limit mid-sweep
  task automatic run_sweep(input int s, input int lim, input bit hold);
    int orw, n, v;
    int q[$];
    logic [1:0] e;
    orw = (s == 2) ? 1 : 3;
    sel = s;
    yv_n = 0; y1_n = 0; vv_n = 0; done_at = -1; done_n = 0; seq_err = 0; y_err = 0;
    vv_at[0] = -1; vv_at[1] = -1; vv_at[2] = -1;
    sig_m = '0;
    if (s == 0) limit_a = 6'(lim);
    else if (s == 1) limit_b = 6'(lim);
    else limit_c = 4'(lim);
    set_start(s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      limit_a = 6'd63; limit_b = 6'd63; limit_c = 4'd15;
    end else begin
      set_start(s, 1'b0);
    end
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (m_vv) begin
        if (vv_n < 3) vv_at[vv_n] = n;
        if (m_vec !== 8'(vv_n)) seq_err++;
        q.push_back(int'(m_vec));
        vv_n++;
      end
      if (m_yv) begin
        yv_n++;
        if (m_y1) y1_n++;
        if (q.size() == 0) y_err++;
        else begin
          v = q.pop_front();
          e = model_y(v, orw);
          if ({m_y1, m_y2} !== e) y_err++;
          sig_m = {sig_m[14:0], sig_m[15]} ^ {14'b0, e};
        end
      end
      if (m_done) begin
        done_n++;
        if (done_at < 0) done_at = n;
      end
      if (done_at >= 0 && n == done_at + 1) set_start(s, 1'b0);
      if (done_at >= 0 && n == done_at + 3) break;
    end
    set_start(s, 1'b0);
    busy_after = m_busy;
  endtask

  initial begin
    int waited;
    sel = 0;
    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    limit_a = 0; limit_b = 0; limit_c = 0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_vec", vec_a, 0);
    chk("rst_vec_valid", vv_a, 0);
    chk("rst_y1y2", {y1_a, y2_a}, 0);
    chk("rst_y_valid", yv_a, 0);
    chk("rst_y1_count", y1c_a, 0);
    chk("rst_y2_count", y2c_a, 0);
    chk("rst_busy_bc", {busy_b, busy_c}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full sweep of all 64 vectors
    run_sweep(0, 63, 0);
    chk("full_y_valid", yv_n, 64);
    chk("full_vec_valid", vv_n, 64);
    chk("full_y1_count", m_y1c, 32);
    chk("full_y2_count", m_y2c, 14);
    chk("full_y1_seen", y1_n, 32);
    chk("full_done_at", done_at, 67);
    chk("full_done_n", done_n, 1);
    chk("full_busy_after", busy_after, 0);
    chk("full_seq_err", seq_err, 0);
    chk("full_y_err", y_err, 0);

    // limit=5 with start held through done and limit moved after acceptance
    run_sweep(0, 5, 1);
    chk("l5_y_valid", yv_n, 6);
    chk("l5_y1_count", m_y1c, 4);
    chk("l5_y2_count", m_y2c, 2);
    chk("l5_vv_at0", vv_at[0], 1);
    chk("l5_vv_at1", vv_at[1], 2);
    chk("l5_vv_at2", vv_at[2], 3);
    chk("l5_done_at", done_at, 9);
    chk("l5_done_n", done_n, 1);
    chk("l5_busy_after", busy_after, 0);
    chk("l5_y_err", y_err, 0);

    run_sweep(0, 0, 0);
    chk("l0_y_valid", yv_n, 1);
    chk("l0_y1_seen", y1_n, 0);
    chk("l0_y1_count", m_y1c, 0);
    chk("l0_y2_count", m_y2c, 0);
    chk("l0_done_at", done_at, 4);
    chk("l0_y_err", y_err, 0);

    // DWELL=3 instance
    run_sweep(1, 2, 0);
    chk("dw3_vv_at0", vv_at[0], 1);
    chk("dw3_vv_at1", vv_at[1], 4);
    chk("dw3_vv_at2", vv_at[2], 7);
    chk("dw3_vec_valid", vv_n, 3);
    chk("dw3_y_valid", yv_n, 3);
    chk("dw3_done_at", done_at, 10);
    chk("dw3_y1_count", m_y1c, 1);
    chk("dw3_y2_count", m_y2c, 0);
    chk("dw3_y_err", y_err, 0);

    // Restarts hammered during a sweep, then rst at vector 10
    sel = 0;
    limit_a = 6'd63;
    start_a = 1'b1;
    waited = 0;
    while (!(vv_a && vec_a == 6'd10) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("rstmid_reached_vec10", {vv_a, vec_a}, {1'b1, 6'd10});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b0;
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_vec", vec_a, 0);
    chk("rstmid_valids", {vv_a, yv_a, done_a}, 0);
    chk("rstmid_counts", {y1c_a, y2c_a}, 0);
    @(negedge clk);
    chk("rstmid_idle_after", {busy_a, vv_a, yv_a, y1_a, y2_a}, 0);
    run_sweep(0, 5, 0);
    chk("rstmid_y1_count", m_y1c, 4);
    chk("rstmid_y2_count", m_y2c, 2);
    chk("rstmid_y_valid", yv_n, 6);
    chk("rstmid_done_at", done_at, 9);

    // OR_W=1 instance, full 16-vector sweep
    run_sweep(2, 15, 0);
    chk("or1_y_valid", yv_n, 16);
    chk("or1_y1_count", m_y1c, 8);
    chk("or1_y2_count", m_y2c, 2);
    chk("or1_done_at", done_at, 19);
    chk("or1_y_err", y_err, 0);
`ifdef BOOL_SWEEP_SIGNATURE_EN
    chk("or1_signature", m_sig, sig_m);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
